block_decode_dc_diff: RTL and testbench

Bit-serial decoder for the MPEG-2 intra `dct_dc_differential` field, and the stage directly downstream of the DC size VLC decoder. It receives the decoded `dct_dc_size` and shifts exactly that many bits from the slice bitstream. It reconstructs the differential and updates the per-component DC predictor (Y, Cb, Cr). It then emits both the predictor value and the dequantized DC coefficient F''[0][0] to the block reconstruction path.

---
 rtl/block_decode_dc_diff.sv | 193 +++++++++++++++++++
 tb/tb_block_decode_dc_diff.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_decode_dc_diff.sv
// block_decode_dc_diff
//
// Bit-serial decoder for the MPEG-2 intra dct_dc_differential field. It sits
// directly after the DC size VLC decoder. On Start_I it shifts Size_I bits
// MSB-first from the slice bitstream and rebuilds the signed differential.
// It then adds the differential to the predictor of the selected component
// (Y/Cb/Cr) and presents the new predictor together with the dequantized
// DC coefficient F''[0][0].
//
// Optional feature macro: DC_RANGE_CHECK_EN
//   defined   : an out-of-range predictor saturates to 0 / 2^(8+prec)-1 and
//               pulses Error_O together with DC_Valid_O.
//   undefined : the predictor wraps modulo 2^(8+prec). Error_O only reports
//               an illegal size.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   Start_I               one-cycle start; Size_I/Component_I valid (only while !Busy_O)
//   Size_I[3:0]           dct_dc_size, legal 0..11
//   Component_I[1:0]      0=Y 1=Cb 2=Cr (3 treated as Cr)
//   Intra_DC_Precision_I  picture intra_dc_precision 0..3
//   Pred_Reset_I          resets all predictors; aborts a decode in flight
//   Data_In_I             bitstream bit, consumed when Shift_En_O=1
//   Shift_En_O            bit consumed this cycle
//   Busy_O                decode in progress (SHIFT or UPDATE)
//   DC_Valid_O            one-cycle result strobe
//   DC_Pred_O[10:0]       updated predictor
//   DC_Coeff_O[11:0]      DC_Pred_O * (8 >> precision)
//   Error_O               illegal size / range error pulse
//
// Handshake: Start_I is a request pulse that is taken only in a cycle where
// Busy_O=0 (IDLE or DONE); a pulse seen while busy is ignored. DC_Valid_O is
// a one-cycle strobe with no back-pressure. The result registers hold until
// the next UPDATE.

module block_decode_dc_diff (
  input  logic        clock,
  input  logic        reset,
  input  logic        Start_I,
  input  logic [3:0]  Size_I,
  input  logic [1:0]  Component_I,
  input  logic [1:0]  Intra_DC_Precision_I,
  input  logic        Pred_Reset_I,
  input  logic        Data_In_I,
  output logic        Shift_En_O,
  output logic        Busy_O,
  output logic        DC_Valid_O,
  output logic [10:0] DC_Pred_O,
  output logic [11:0] DC_Coeff_O,
  output logic        Error_O
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_UPDATE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  size_q;
  logic [1:0]  comp_q;
  logic [3:0]  cnt_q;
  logic [10:0] bits_q;
  logic [10:0] pred_y_q, pred_cb_q, pred_cr_q;

  logic        accept;
  logic        size_legal;
  logic [10:0] pred_rst;
  logic [10:0] pred_cur;
  logic [10:0] max_val;
  logic [10:0] span;
  logic [10:0] bits_sh;
  logic        msb;
  logic [10:0] diff_lo;
  logic [10:0] pred_new;
  logic [11:0] coeff_new;
  logic        range_err;

  assign accept     = Start_I && (state_q == S_IDLE || state_q == S_DONE);
  assign size_legal = (Size_I <= 4'd11);
  assign pred_rst   = 11'd128 << Intra_DC_Precision_I;

  assign Shift_En_O = (state_q == S_SHIFT);
  assign Busy_O     = (state_q == S_SHIFT) || (state_q == S_UPDATE);
  assign DC_Valid_O = (state_q == S_DONE);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept && size_legal)
          state_d = (Size_I == 4'd0) ? S_UPDATE : S_SHIFT;
      end
      S_SHIFT: begin
        if (Pred_Reset_I)        state_d = S_IDLE;
        else if (cnt_q == 4'd1)  state_d = S_UPDATE;
      end
      S_UPDATE: state_d = Pred_Reset_I ? S_IDLE : S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Differential reconstruction and predictor update
  always_comb begin
    pred_cur = pred_cr_q;
    case (comp_q)
      2'd0:    pred_cur = pred_y_q;
      2'd1:    pred_cur = pred_cb_q;
      default: pred_cur = pred_cr_q;
    endcase
  end

  // 2^(8+prec)-1; for prec 3 the shift overflows 11 bits to 0 and the
  // subtraction wraps to 2047, which is exactly the required mask.
  assign max_val = (11'd1 << (4'd8 + {2'b00, Intra_DC_Precision_I})) - 11'd1;
  assign span    = (11'd1 << size_q) - 11'd1;
  assign bits_sh = bits_q >> (size_q - 4'd1);
  assign msb     = (size_q != 4'd0) && bits_sh[0];
  // Low 11 bits of the differential; for size 0 bits_q and span are both 0.
  assign diff_lo = msb ? bits_q : (bits_q - span);

`ifdef DC_RANGE_CHECK_EN
  logic        diff_neg;
  logic [12:0] sum;
  // The differential is negative exactly when the leading bit is 0 (size>0).
  // The sign is kept separately because +/-2047 does not fit 11 bits signed.
  assign diff_neg = !msb && (size_q != 4'd0);
  assign sum      = {2'b00, pred_cur} + {{2{diff_neg}}, diff_lo};
  always_comb begin
    pred_new  = sum[10:0];
    range_err = 1'b0;
    if (sum[12]) begin
      pred_new  = 11'd0;
      range_err = 1'b1;
    end else if (sum > {2'b00, max_val}) begin
      pred_new  = max_val;
      range_err = 1'b1;
    end
  end
`else
  assign pred_new  = (pred_cur + diff_lo) & max_val;
  assign range_err = 1'b0;
`endif

  assign coeff_new = {1'b0, pred_new} << (2'd3 - Intra_DC_Precision_I);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      size_q     <= 4'd0;
      comp_q     <= 2'd0;
      cnt_q      <= 4'd0;
      bits_q     <= 11'd0;
      pred_y_q   <= 11'd128;
      pred_cb_q  <= 11'd128;
      pred_cr_q  <= 11'd128;
      DC_Pred_O  <= 11'd0;
      DC_Coeff_O <= 12'd0;
      Error_O    <= 1'b0;
    end else begin
      Error_O <= 1'b0;
      if (accept) begin
        size_q <= Size_I;
        comp_q <= (Component_I == 2'd3) ? 2'd2 : Component_I;
        cnt_q  <= Size_I;
        bits_q <= 11'd0;
        if (!size_legal) Error_O <= 1'b1;
      end
      if (state_q == S_SHIFT) begin
        bits_q <= {bits_q[9:0], Data_In_I};
        cnt_q  <= cnt_q - 4'd1;
      end
      // A predictor reset wins over an UPDATE in the same cycle (abort).
      if (Pred_Reset_I) begin
        pred_y_q  <= pred_rst;
        pred_cb_q <= pred_rst;
        pred_cr_q <= pred_rst;
      end else if (state_q == S_UPDATE) begin
        case (comp_q)
          2'd0:    pred_y_q  <= pred_new;
          2'd1:    pred_cb_q <= pred_new;
          default: pred_cr_q <= pred_new;
        endcase
        DC_Pred_O  <= pred_new;
        DC_Coeff_O <= coeff_new;
        Error_O    <= range_err;
      end
    end
  end

endmodule

// File: tb/tb_block_decode_dc_diff.sv
// Testbench for block_decode_dc_diff: directed table of decodes with
// hand-computed results, plus hand-written abort and back-to-back sequences.

module tb_block_decode_dc_diff;

  // Clock / reset
  logic        clock = 1'b0;
  logic        reset;
  logic        Start_I;
  logic [3:0]  Size_I;
  logic [1:0]  Component_I;
  logic [1:0]  Intra_DC_Precision_I;
  logic        Pred_Reset_I;
  logic        Data_In_I;
  logic        Shift_En_O;
  logic        Busy_O;
  logic        DC_Valid_O;
  logic [10:0] DC_Pred_O;
  logic [11:0] DC_Coeff_O;
  logic        Error_O;

  always #5 clock = ~clock;

  block_decode_dc_diff dut (
    .clock                (clock),
    .reset                (reset),
    .Start_I              (Start_I),
    .Size_I               (Size_I),
    .Component_I          (Component_I),
    .Intra_DC_Precision_I (Intra_DC_Precision_I),
    .Pred_Reset_I         (Pred_Reset_I),
    .Data_In_I            (Data_In_I),
    .Shift_En_O           (Shift_En_O),
    .Busy_O               (Busy_O),
    .DC_Valid_O           (DC_Valid_O),
    .DC_Pred_O            (DC_Pred_O),
    .DC_Coeff_O           (DC_Coeff_O),
    .Error_O              (Error_O)
  );

  // Scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Driver: issue one decode in the current cycle (cycle 0) and observe the
  // following 16 cycles. Cycle numbers of the first strobe/error are returned
  // (-1 if never seen).
  task automatic run_decode(input logic preset, input logic [1:0] comp,
                            input logic [3:0] size, input logic [10:0] bits,
                            output int shifts, output int valid_cyc,
                            output int nvalid, output int err_cyc,
                            output logic [10:0] pred, output logic [11:0] coeff);
    int bi;
    shifts = 0; valid_cyc = -1; nvalid = 0; err_cyc = -1;
    pred = '0; coeff = '0;
    bi = int'(size);
    Start_I = 1'b1; Size_I = size; Component_I = comp; Pred_Reset_I = preset;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      tick();
      Start_I = 1'b0;
      Pred_Reset_I = 1'b0;
      Data_In_I = 1'b0;
      if (Shift_En_O) begin
        shifts++;
        if (bi > 0) Data_In_I = bits[bi-1];
        bi--;
      end
      if (DC_Valid_O) begin
        nvalid++;
        if (valid_cyc < 0) begin
          valid_cyc = cyc;
          pred = DC_Pred_O;
          coeff = DC_Coeff_O;
        end
      end
      if (Error_O && err_cyc < 0) err_cyc = cyc;
    end
  endtask

  typedef struct {
    logic [1:0]  prec;
    logic        preset;
    logic [1:0]  comp;
    logic [3:0]  size;
    logic [10:0] bits;
    int          shifts;
    int          valid_cyc;
    int          err_cyc;
    logic        chk_pred;
    logic [10:0] pred;
    logic [11:0] coeff;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin
    int sh, vc, nv, ec, nval, nerr;
    logic [10:0] pr;
    logic [11:0] co;

    // prec preset comp size bits shifts valid err chk pred coeff
    vecs[0]  = '{2'd0, 1'b0, 2'd0, 4'd3,  11'b101,         3, 5, -1, 1'b1, 11'd133, 12'd1064};
    vecs[1]  = '{2'd0, 1'b0, 2'd0, 4'd3,  11'b010,         3, 5, -1, 1'b1, 11'd128, 12'd1024};
    vecs[2]  = '{2'd0, 1'b0, 2'd1, 4'd0,  11'b0,           0, 2, -1, 1'b1, 11'd128, 12'd1024};
    vecs[3]  = '{2'd0, 1'b0, 2'd1, 4'd2,  11'b11,          2, 4, -1, 1'b1, 11'd131, 12'd1048};
    vecs[4]  = '{2'd0, 1'b0, 2'd2, 4'd1,  11'b0,           1, 3, -1, 1'b1, 11'd127, 12'd1016};
    vecs[5]  = '{2'd0, 1'b0, 2'd0, 4'd0,  11'b0,           0, 2, -1, 1'b1, 11'd128, 12'd1024};
    vecs[6]  = '{2'd0, 1'b0, 2'd0, 4'd12, 11'b0,           0, -1, 1, 1'b0, 11'd0,   12'd0};
    vecs[7]  = '{2'd0, 1'b0, 2'd0, 4'd0,  11'b0,           0, 2, -1, 1'b1, 11'd128, 12'd1024};
    vecs[8]  = '{2'd0, 1'b0, 2'd0, 4'd7,  11'b1111111,     7, 9, -1, 1'b1, 11'd255, 12'd2040};
`ifdef DC_RANGE_CHECK_EN
    vecs[9]  = '{2'd0, 1'b0, 2'd0, 4'd8,  11'b11111111,    8, 10, 10, 1'b1, 11'd255, 12'd2040};
`else
    vecs[9]  = '{2'd0, 1'b0, 2'd0, 4'd8,  11'b11111111,    8, 10, -1, 1'b1, 11'd254, 12'd2032};
`endif
    vecs[10] = '{2'd2, 1'b1, 2'd0, 4'd0,  11'b0,           0, 2, -1, 1'b1, 11'd512, 12'd1024};
    vecs[11] = '{2'd2, 1'b0, 2'd1, 4'd3,  11'b100,         3, 5, -1, 1'b1, 11'd516, 12'd1032};
    vecs[12] = '{2'd3, 1'b1, 2'd3, 4'd10, 11'b1000000000, 10, 12, -1, 1'b1, 11'd1536, 12'd1536};
`ifdef DC_RANGE_CHECK_EN
    vecs[13] = '{2'd1, 1'b1, 2'd0, 4'd9,  11'b0,           9, 11, 11, 1'b1, 11'd0,   12'd0};
`else
    vecs[13] = '{2'd1, 1'b1, 2'd0, 4'd9,  11'b0,           9, 11, -1, 1'b1, 11'd257, 12'd1028};
`endif

    // Reset
    reset = 1'b1; Start_I = 1'b0; Size_I = '0; Component_I = '0;
    Intra_DC_Precision_I = 2'd0; Pred_Reset_I = 1'b0; Data_In_I = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_shift_en", 32'(Shift_En_O), 0);
    chk("reset_busy",     32'(Busy_O), 0);
    chk("reset_valid",    32'(DC_Valid_O), 0);
    chk("reset_pred",     32'(DC_Pred_O), 0);
    chk("reset_coeff",    32'(DC_Coeff_O), 0);
    chk("reset_error",    32'(Error_O), 0);
    reset = 1'b0;
    tick();

    // Table-driven decodes
    for (int i = 0; i < NV; i++) begin
      Intra_DC_Precision_I = vecs[i].prec;
      run_decode(vecs[i].preset, vecs[i].comp, vecs[i].size, vecs[i].bits,
                 sh, vc, nv, ec, pr, co);
      chk($sformatf("v%0d_shifts", i), sh, vecs[i].shifts);
      chk($sformatf("v%0d_valid_cycle", i), vc, vecs[i].valid_cyc);
      chk($sformatf("v%0d_valid_count", i), nv, (vecs[i].valid_cyc < 0) ? 0 : 1);
      chk($sformatf("v%0d_error_cycle", i), ec, vecs[i].err_cyc);
      if (vecs[i].chk_pred) begin
        chk($sformatf("v%0d_pred", i), 32'(pr), 32'(vecs[i].pred));
        chk($sformatf("v%0d_coeff", i), 32'(co), 32'(vecs[i].coeff));
      end
    end

    // Abort mid-SHIFT: predictors go back to 128 and no strobe appears.
    Intra_DC_Precision_I = 2'd0;
    Pred_Reset_I = 1'b1;
    tick();
    Pred_Reset_I = 1'b0;
    run_decode(1'b0, 2'd0, 4'd2, 11'b10, sh, vc, nv, ec, pr, co);
    chk("pre_abort_pred", 32'(pr), 130);
    Start_I = 1'b1; Size_I = 4'd5; Component_I = 2'd0;   // cycle 0
    tick();                                              // cycle 1
    Start_I = 1'b0; Data_In_I = 1'b1;
    chk("abort_shift_c1", 32'(Shift_En_O), 1);
    tick();                                              // cycle 2
    Pred_Reset_I = 1'b1;
    tick();                                              // cycle 3
    Pred_Reset_I = 1'b0;
    chk("abort_busy_c3", 32'(Busy_O), 0);
    nval = 0; nerr = 0;
    for (int c = 0; c < 15; c++) begin
      if (DC_Valid_O) nval++;
      if (Error_O) nerr++;
      if (Shift_En_O) nerr++;
      tick();
    end
    chk("abort_no_valid", nval, 0);
    chk("abort_no_error_or_shift", nerr, 0);
    run_decode(1'b0, 2'd0, 4'd0, 11'b0, sh, vc, nv, ec, pr, co);
    chk("post_abort_pred", 32'(pr), 128);

    // Back-to-back: second Start in the DONE cycle of the first decode.
    Start_I = 1'b1; Size_I = 4'd1; Component_I = 2'd0;   // cycle 0
    tick();                                              // cycle 1
    Start_I = 1'b0; Data_In_I = 1'b1;
    chk("b2b_shift_c1", 32'(Shift_En_O), 1);
    tick();                                              // cycle 2 (UPDATE)
    Data_In_I = 1'b0;
    chk("b2b_busy_c2", 32'(Busy_O), 1);
    tick();                                              // cycle 3 (DONE)
    chk("b2b_valid_c3", 32'(DC_Valid_O), 1);
    chk("b2b_busy_c3", 32'(Busy_O), 0);
    chk("b2b_pred_c3", 32'(DC_Pred_O), 129);
    Start_I = 1'b1; Size_I = 4'd1; Component_I = 2'd0;
    tick();                                              // cycle 4
    Start_I = 1'b0; Data_In_I = 1'b1;
    chk("b2b_shift_c4", 32'(Shift_En_O), 1);
    tick();                                              // cycle 5
    Data_In_I = 1'b0;
    chk("b2b_valid_c5", 32'(DC_Valid_O), 0);
    chk("b2b_pred_hold_c5", 32'(DC_Pred_O), 129);
    tick();                                              // cycle 6
    chk("b2b_valid_c6", 32'(DC_Valid_O), 1);
    chk("b2b_pred_c6", 32'(DC_Pred_O), 130);
    chk("b2b_coeff_c6", 32'(DC_Coeff_O), 1040);
    tick();
    chk("b2b_idle_after", 32'(DC_Valid_O), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
